// File: rtl/dmem_arbiter.sv
// Shares one data-memory port: core has in-cycle priority, UART gets a starvation guard and locked bursts.
// Core served in 0 cycles (stalled on loss); UART gets uart_gnt combinationally and uart_done one cycle later.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int MEM_BYTES  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_size,
  output logic        core_stall,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        uart_req,
  input  logic        uart_we,
  input  logic        uart_lock,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [2:0]  uart_size,
  output logic        uart_gnt,
  output logic        uart_done,
  output logic [31:0] uart_rdata,
  output logic        uart_err,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {SHARED, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic        starved;
  logic        uart_sel, core_sel, any_sel;
  logic        sel_we, sel_legal;
  logic [31:0] sel_addr, sel_wdata;
  logic [2:0]  sel_size;

  // Size/alignment/range check; 33-bit end address so addresses near 2^32 cannot wrap into range.
  function automatic logic access_legal(input logic [31:0] addr, input logic [2:0] size);
    logic [32:0] end_addr;
    logic        ok;
    ok       = 1'b1;
    end_addr = {1'b0, addr};
    case (size)
      3'b000: end_addr = end_addr + 33'd1;
      3'b001: begin
        ok       = ~addr[0];
        end_addr = end_addr + 33'd2;
      end
      3'b010: begin
        ok       = (addr[1:0] == 2'b00);
        end_addr = end_addr + 33'd4;
      end
      default: ok = 1'b0;
    endcase
    return ok && (end_addr <= 33'(MEM_BYTES));
  endfunction

  always_comb begin
    starved  = (wait_cnt == 4'(STARVE_MAX));
    uart_sel = 1'b0;
    core_sel = 1'b0;
    if (state == LOCKED) begin
      uart_sel = uart_req;
    end else begin
      uart_sel = uart_req && (!core_req || starved);
      core_sel = core_req && !uart_sel;
    end
    any_sel = uart_sel || core_sel;

    sel_we    = uart_sel ? uart_we    : core_we;
    sel_addr  = uart_sel ? uart_addr  : core_addr;
    sel_wdata = uart_sel ? uart_wdata : core_wdata;
    sel_size  = uart_sel ? uart_size  : core_size;
    sel_legal = access_legal(sel_addr, sel_size);

    // Illegal grants still present their fields but never enable the memory.
    mem_wr_en = any_sel && sel_legal && sel_we;
    mem_rd_en = any_sel && sel_legal && !sel_we;
    mem_addr  = any_sel ? sel_addr  : 32'd0;
    mem_wdata = any_sel ? sel_wdata : 32'd0;
    mem_size  = any_sel ? sel_size  : 3'd0;

    core_stall = core_req && !core_sel;
    core_err   = core_sel && !sel_legal;
    core_rdata = (core_sel && sel_legal && !core_we) ? mem_rdata : 32'd0;
    uart_gnt   = uart_sel;

    state_nxt = state;
    case (state)
      SHARED: if (uart_sel && uart_lock) state_nxt = LOCKED;
      LOCKED: if (!uart_lock) state_nxt = SHARED;
      default: state_nxt = SHARED;
    endcase

    wait_nxt = wait_cnt;
    if (uart_sel || !uart_req) begin
      wait_nxt = 4'd0;
    end else if (core_sel && !starved) begin
      wait_nxt = wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SHARED;
      wait_cnt   <= 4'd0;
      uart_done  <= 1'b0;
      uart_err   <= 1'b0;
      uart_rdata <= 32'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      uart_done <= uart_sel;
      uart_err  <= uart_sel && !sel_legal;
      if (uart_sel) begin
        uart_rdata <= (sel_legal && !uart_we) ? mem_rdata : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed checks of dmem_arbiter against a byte-addressed memory model (negedge writes, combinational reads).
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_size;
  logic        core_stall, core_err;
  logic [31:0] core_rdata;
  logic        uart_req, uart_we, uart_lock;
  logic [31:0] uart_addr, uart_wdata;
  logic [2:0]  uart_size;
  logic        uart_gnt, uart_done, uart_err;
  logic [31:0] uart_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;

  logic [7:0]  mem [256];
  logic        mem_clr;
  logic [7:0]  ra;

  int nchk = 0;
  int nerr = 0;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  dmem_arbiter #(.STARVE_MAX(4), .MEM_BYTES(256)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_size(core_size),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_err(core_err),
    .uart_req(uart_req), .uart_we(uart_we), .uart_lock(uart_lock),
    .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_size(uart_size),
    .uart_gnt(uart_gnt), .uart_done(uart_done), .uart_rdata(uart_rdata), .uart_err(uart_err),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ra        = mem_addr[7:0];
  assign mem_rdata = {mem[8'(ra + 8'd3)], mem[8'(ra + 8'd2)], mem[8'(ra + 8'd1)], mem[ra]};

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_wr_en) begin
      mem[ra] <= mem_wdata[7:0];
      if (mem_size != SZ_B) mem[8'(ra + 8'd1)] <= mem_wdata[15:8];
      if (mem_size == SZ_W) begin
        mem[8'(ra + 8'd2)] <= mem_wdata[23:16];
        mem[8'(ra + 8'd3)] <= mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic        c_req, c_we;
    logic [2:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    logic        u_req, u_we;
    logic [2:0]  u_size;
    logic [31:0] u_addr, u_wdata;
    logic        x_stall, x_cerr, x_gnt, x_wr, x_rd, chk_addr;
    logic [31:0] x_maddr, x_crdata;
    logic        x_done, x_uerr;
    logic [31:0] x_urdata;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t v(
    input logic c_req, input logic c_we, input logic [2:0] c_size,
    input logic [31:0] c_addr, input logic [31:0] c_wdata,
    input logic u_req, input logic u_we, input logic [2:0] u_size,
    input logic [31:0] u_addr, input logic [31:0] u_wdata,
    input logic x_stall, input logic x_cerr, input logic x_gnt,
    input logic x_wr, input logic x_rd, input logic chk_addr,
    input logic [31:0] x_maddr, input logic [31:0] x_crdata,
    input logic x_done, input logic x_uerr, input logic [31:0] x_urdata);
    vec_t r;
    r.c_req = c_req; r.c_we = c_we; r.c_size = c_size; r.c_addr = c_addr; r.c_wdata = c_wdata;
    r.u_req = u_req; r.u_we = u_we; r.u_size = u_size; r.u_addr = u_addr; r.u_wdata = u_wdata;
    r.x_stall = x_stall; r.x_cerr = x_cerr; r.x_gnt = x_gnt; r.x_wr = x_wr; r.x_rd = x_rd;
    r.chk_addr = chk_addr; r.x_maddr = x_maddr; r.x_crdata = x_crdata;
    r.x_done = x_done; r.x_uerr = x_uerr; r.x_urdata = x_urdata;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_core(input logic rq, input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    core_req = rq; core_we = we; core_size = sz; core_addr = a; core_wdata = d;
  endtask

  task automatic set_uart(input logic rq, input logic we, input logic lk, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    uart_req = rq; uart_we = we; uart_lock = lk; uart_size = sz; uart_addr = a; uart_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic prev_gnt;
  logic exp_g;

  initial begin
    reset = 1'b0;
    mem_clr = 1'b1;
    set_core(0, 0, SZ_B, 0, 0);
    set_uart(0, 0, 0, SZ_B, 0, 0);

    vecs[0]  = v(1,1,SZ_W,32'h10,32'hDEADBEEF, 0,0,SZ_B,0,0,          0,0,0,1,0,1,32'h10,0,            0,0,0);
    vecs[1]  = v(1,0,SZ_B,32'h10,0,            0,0,SZ_B,0,0,          0,0,0,0,1,1,32'h10,32'hDEADBEEF, 0,0,0);
    vecs[2]  = v(1,1,SZ_W,32'h20,32'h12345678, 0,0,SZ_B,0,0,          0,0,0,1,0,1,32'h20,0,            0,0,0);
    vecs[3]  = v(0,0,SZ_B,0,0,                 1,0,SZ_W,32'h20,0,     0,0,1,0,1,1,32'h20,0,            0,0,0);
    vecs[4]  = v(0,0,SZ_B,0,0,                 0,0,SZ_B,0,0,          0,0,0,0,0,1,0,0,                 1,0,32'h12345678);
    vecs[5]  = v(1,0,SZ_H,32'h03,0,            0,0,SZ_B,0,0,          0,1,0,0,0,0,0,0,                 0,0,0);
    vecs[6]  = v(1,1,SZ_W,32'h02,32'h11,       0,0,SZ_B,0,0,          0,1,0,0,0,0,0,0,                 0,0,0);
    vecs[7]  = v(1,0,SZ_W,32'hFE,0,            0,0,SZ_B,0,0,          0,1,0,0,0,0,0,0,                 0,0,0);
    vecs[8]  = v(1,0,3'b011,32'h00,0,          0,0,SZ_B,0,0,          0,1,0,0,0,0,0,0,                 0,0,0);
    vecs[9]  = v(1,0,SZ_W,32'hFC,0,            0,0,SZ_B,0,0,          0,0,0,0,1,1,32'hFC,0,            0,0,0);
    vecs[10] = v(0,0,SZ_B,0,0,                 1,1,SZ_H,32'h03,32'hBEEF, 0,0,1,0,0,0,0,0,              0,0,0);
    vecs[11] = v(0,0,SZ_B,0,0,                 1,1,SZ_B,32'hFF,32'hA5,   0,0,1,1,0,1,32'hFF,0,         1,1,0);
    vecs[12] = v(1,0,SZ_B,32'hFF,0,            0,0,SZ_B,0,0,          0,0,0,0,1,1,32'hFF,32'h000000A5, 1,0,0);

    step();
    step();
    chk("rst_uart_done", 32'(uart_done), 0);
    chk("rst_uart_err", 32'(uart_err), 0);
    chk("rst_uart_rdata", uart_rdata, 0);
    chk("rst_idle_mem_wr", 32'(mem_wr_en), 0);
    chk("rst_idle_stall", 32'(core_stall), 0);
    reset = 1'b1;
    mem_clr = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step();
      set_core(vecs[i].c_req, vecs[i].c_we, vecs[i].c_size, vecs[i].c_addr, vecs[i].c_wdata);
      set_uart(vecs[i].u_req, vecs[i].u_we, 1'b0, vecs[i].u_size, vecs[i].u_addr, vecs[i].u_wdata);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d_core_err", i), 32'(core_err), 32'(vecs[i].x_cerr));
      chk($sformatf("v%0d_uart_gnt", i), 32'(uart_gnt), 32'(vecs[i].x_gnt));
      chk($sformatf("v%0d_mem_wr", i), 32'(mem_wr_en), 32'(vecs[i].x_wr));
      chk($sformatf("v%0d_mem_rd", i), 32'(mem_rd_en), 32'(vecs[i].x_rd));
      chk($sformatf("v%0d_core_rdata", i), core_rdata, vecs[i].x_crdata);
      chk($sformatf("v%0d_uart_done", i), 32'(uart_done), 32'(vecs[i].x_done));
      if (vecs[i].chk_addr) chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].x_maddr);
      if (vecs[i].x_done) begin
        chk($sformatf("v%0d_uart_err", i), 32'(uart_err), 32'(vecs[i].x_uerr));
        chk($sformatf("v%0d_uart_rdata", i), uart_rdata, vecs[i].x_urdata);
      end
    end

    // Contention: core wins 4 times, then the starved UART is forced through.
    prev_gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      set_core(1, 0, SZ_B, 32'h10, 0);
      set_uart(1, 0, 0, SZ_W, 32'h20, 0);
      #1;
      exp_g = (i % 5 == 4);
      chk($sformatf("cont%0d_uart_gnt", i), 32'(uart_gnt), 32'(exp_g));
      chk($sformatf("cont%0d_stall", i), 32'(core_stall), 32'(exp_g));
      chk($sformatf("cont%0d_uart_done", i), 32'(uart_done), 32'(prev_gnt));
      if (!exp_g) chk($sformatf("cont%0d_core_rdata", i), core_rdata, 32'hDEADBEEF);
      if (prev_gnt) chk($sformatf("cont%0d_uart_rdata", i), uart_rdata, 32'h12345678);
      prev_gnt = exp_g;
    end
    step();
    set_core(0, 0, SZ_B, 0, 0);
    set_uart(0, 0, 0, SZ_B, 0, 0);
    #1;
    chk("cont_tail_done", 32'(uart_done), 32'(prev_gnt));
    chk("cont_tail_rdata", uart_rdata, 32'h12345678);
    chk("cont_tail_err", 32'(uart_err), 0);

    // Locked burst of three UART writes; the core is held off until the lock drops.
    step();
    set_uart(1, 1, 1, SZ_W, 32'h40, 32'hCAFE0040);
    #1;
    chk("lock0_gnt", 32'(uart_gnt), 1);
    step();
    set_core(1, 0, SZ_W, 32'h40, 0);
    set_uart(1, 1, 1, SZ_W, 32'h44, 32'hCAFE0044);
    #1;
    chk("lock1_gnt", 32'(uart_gnt), 1);
    chk("lock1_stall", 32'(core_stall), 1);
    chk("lock1_addr", mem_addr, 32'h44);
    step();
    set_uart(1, 1, 0, SZ_W, 32'h48, 32'hCAFE0048);
    #1;
    chk("lock2_gnt", 32'(uart_gnt), 1);
    chk("lock2_stall", 32'(core_stall), 1);
    chk("lock2_wr", 32'(mem_wr_en), 1);
    step();
    set_uart(0, 0, 0, SZ_B, 0, 0);
    #1;
    chk("unlock_stall", 32'(core_stall), 0);
    chk("unlock_core_rdata", core_rdata, 32'hCAFE0040);
    step();
    set_core(1, 0, SZ_W, 32'h44, 0);
    #1;
    chk("burst_readback", core_rdata, 32'hCAFE0044);

    // Reset while LOCKED with a completion pending.
    step();
    set_core(0, 0, SZ_B, 0, 0);
    set_uart(1, 0, 1, SZ_W, 32'h20, 0);
    #1;
    chk("prelock_gnt", 32'(uart_gnt), 1);
    step();
    chk("pre_reset_done", 32'(uart_done), 1);
    reset = 1'b0;
    set_core(1, 0, SZ_B, 32'h10, 0);
    #1;
    chk("rst_lock_done", 32'(uart_done), 0);
    chk("rst_lock_rdata", uart_rdata, 0);
    chk("rst_lock_uart_gnt", 32'(uart_gnt), 0);
    chk("rst_lock_stall", 32'(core_stall), 0);
    chk("rst_lock_core_rdata", core_rdata, 32'hDEADBEEF);
    step();
    chk("rst_hold_done", 32'(uart_done), 0);
    reset = 1'b1;
    set_core(0, 0, SZ_B, 0, 0);
    set_uart(0, 0, 0, SZ_B, 0, 0);
    step();
    #1;
    chk("post_rst_done", 32'(uart_done), 0);
    chk("post_rst_idle_rd", 32'(mem_rd_en), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
